// File: rtl/mist1032sa_uart_receiver_fifo.sv
// mist1032sa_uart_receiver_fifo
//   Single-clock UART receiver with oversampled bit-centre sampling, start-glitch
//   rejection, stop-bit framing check, optional parity and a first-word-fall-through
//   receive FIFO popped by the UART register block.
//   Optional feature macro: MIST1032SA_UART_RX_PARITY_EN (adds one parity bit per frame).
// Ports
//   iCLOCK, inRESET       clock, async active-low reset
//   iEXTBAUD_COUNT        runtime tick period-1 (used when BAUDRATE_FIXED=0)
//   iUART_RXD             async serial input, idle high
//   oRX_VALID / oRX_DATA / oRX_FRAME_ERR / oRX_PARITY_ERR   FIFO head entry
//   iRX_REQ               pop head entry
//   oRX_COUNT             entries held
//   oOVERRUN / iCLEAR_OVERRUN   sticky dropped-byte flag and its clear
`timescale 1ns/1ps

module mist1032sa_uart_receiver_fifo #(
    parameter bit          BAUDRATE_FIXED   = 1'b1,
    parameter logic [19:0] BAUDRATE_COUNTER = 20'd26,
    parameter int unsigned OVERSAMPLE       = 16,
    parameter int unsigned DATA_BITS        = 8,
    parameter int unsigned FIFO_DEPTH       = 16,
    parameter int unsigned FIFO_AW          = 4,
    parameter bit          PARITY_ODD       = 1'b0
) (
    input  logic                 iCLOCK,
    input  logic                 inRESET,
    input  logic [19:0]          iEXTBAUD_COUNT,
    input  logic                 iUART_RXD,
    output logic                 oRX_VALID,
    output logic [DATA_BITS-1:0] oRX_DATA,
    output logic                 oRX_FRAME_ERR,
    output logic                 oRX_PARITY_ERR,
    input  logic                 iRX_REQ,
    output logic [FIFO_AW:0]     oRX_COUNT,
    output logic                 oOVERRUN,
    input  logic                 iCLEAR_OVERRUN
);

    localparam int unsigned SCNT_W  = $clog2(OVERSAMPLE);
    localparam int unsigned BCNT_W  = $clog2(DATA_BITS);
    localparam int unsigned ENTRY_W = DATA_BITS + 2;
    localparam logic [SCNT_W-1:0] HALF_LAST = SCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SCNT_W-1:0] FULL_LAST = SCNT_W'(OVERSAMPLE - 1);
    localparam logic [BCNT_W-1:0] BIT_LAST  = BCNT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Baud tick generator: free-running counter, one-clock enable on match
    logic [19:0] baud_cnt;
    logic [19:0] period_c;
    logic        tick_c;

    assign period_c = BAUDRATE_FIXED ? BAUDRATE_COUNTER : iEXTBAUD_COUNT;
    assign tick_c   = (baud_cnt == period_c);

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) baud_cnt <= '0;
        else          baud_cnt <= tick_c ? '0 : baud_cnt + 20'd1;
    end

    // Two-flop synchroniser, preset to line idle
    logic rxd_meta, rxd_s;

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
        end else begin
            rxd_meta <= iUART_RXD;
            rxd_s    <= rxd_meta;
        end
    end

    // Receive FSM state and datapath registers
    state_t                state, state_n;
    logic [SCNT_W-1:0]     scnt, scnt_n;
    logic [BCNT_W-1:0]     bcnt, bcnt_n;
    logic [DATA_BITS-1:0]  shreg, shreg_n;
    logic                  ferr, ferr_n;
    logic                  perr, perr_n;
    logic                  armed, armed_n;  // low after a 0 stop sample until line returns high
    logic                  push, push_n;

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state <= IDLE;
            scnt  <= '0;
            bcnt  <= '0;
            shreg <= '0;
            ferr  <= 1'b0;
            perr  <= 1'b0;
            armed <= 1'b1;
            push  <= 1'b0;
        end else begin
            state <= state_n;
            scnt  <= scnt_n;
            bcnt  <= bcnt_n;
            shreg <= shreg_n;
            ferr  <= ferr_n;
            perr  <= perr_n;
            armed <= armed_n;
            push  <= push_n;
        end
    end

    // Next-state: every step is gated by the baud tick
    always_comb begin
        state_n = state;
        scnt_n  = scnt;
        bcnt_n  = bcnt;
        shreg_n = shreg;
        ferr_n  = ferr;
        perr_n  = perr;
        armed_n = armed | rxd_s;
        push_n  = 1'b0;
        if (tick_c) begin
            unique case (state)
                IDLE: begin
                    if (!rxd_s && armed) begin
                        state_n = START;
                        scnt_n  = '0;
                        perr_n  = 1'b0;
                    end
                end
                START: begin
                    if (scnt == HALF_LAST) begin
                        scnt_n  = '0;
                        bcnt_n  = '0;
                        state_n = rxd_s ? IDLE : DATA;
                    end else begin
                        scnt_n = scnt + SCNT_W'(1);
                    end
                end
                DATA: begin
                    if (scnt == FULL_LAST) begin
                        scnt_n  = '0;
                        shreg_n = {rxd_s, shreg[DATA_BITS-1:1]};
                        bcnt_n  = bcnt + BCNT_W'(1);
                        if (bcnt == BIT_LAST) begin
`ifdef MIST1032SA_UART_RX_PARITY_EN
                            state_n = PARITY;
`else
                            state_n = STOP;
`endif
                        end
                    end else begin
                        scnt_n = scnt + SCNT_W'(1);
                    end
                end
                PARITY: begin
                    if (scnt == FULL_LAST) begin
                        scnt_n  = '0;
                        perr_n  = ((^shreg) ^ rxd_s) != PARITY_ODD;
                        state_n = STOP;
                    end else begin
                        scnt_n = scnt + SCNT_W'(1);
                    end
                end
                STOP: begin
                    if (scnt == FULL_LAST) begin
                        scnt_n  = '0;
                        ferr_n  = !rxd_s;
                        push_n  = 1'b1;
                        state_n = IDLE;
                        if (!rxd_s) armed_n = 1'b0;
                    end else begin
                        scnt_n = scnt + SCNT_W'(1);
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Receive FIFO: a push into a full FIFO succeeds only if the head pops the same clock
    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count_n;
    logic               pop_c, full_c, wr_c, drop_c;
    logic [ENTRY_W-1:0] head_c;

    assign pop_c   = iRX_REQ && oRX_VALID;
    assign full_c  = (oRX_COUNT == (FIFO_AW+1)'(FIFO_DEPTH));
    assign wr_c    = push && (!full_c || pop_c);
    assign drop_c  = push && full_c && !pop_c;
    assign count_n = oRX_COUNT + (FIFO_AW+1)'(wr_c) - (FIFO_AW+1)'(pop_c);

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            oRX_COUNT <= '0;
            oRX_VALID <= 1'b0;
            oOVERRUN  <= 1'b0;
        end else begin
            if (wr_c) begin
                mem[wr_ptr] <= {perr, ferr, shreg};
                wr_ptr      <= wr_ptr + FIFO_AW'(1);
            end
            if (pop_c) rd_ptr <= rd_ptr + FIFO_AW'(1);
            oRX_COUNT <= count_n;
            oRX_VALID <= (count_n != '0);
            // A new overrun wins over a simultaneous clear
            if (drop_c)              oOVERRUN <= 1'b1;
            else if (iCLEAR_OVERRUN) oOVERRUN <= 1'b0;
        end
    end

    // First-word fall-through head view
    assign head_c         = mem[rd_ptr];
    assign oRX_DATA       = head_c[DATA_BITS-1:0];
    assign oRX_FRAME_ERR  = head_c[DATA_BITS];
    assign oRX_PARITY_ERR = head_c[DATA_BITS+1];

endmodule
